// File: rtl/tlp_credit_pkg.sv
// Shared types and helpers for the TLP credit arbiter.
// Latency: n/a (types and a combinational pick function).
// Backpressure: n/a.
package tlp_credit_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Widest requester vector the pick function handles; callers zero-extend.
  localparam int MAX_REQ = 32;

  // Round-robin pick: first set bit of eff scanning upward from ptr+1 with
  // wrap over n requesters. Iterating from the far end down lets the nearest
  // candidate overwrite the rest, so no early exit is needed.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] eff,
                                 input int ptr,
                                 input int n);
    int pick;
    int idx;
    pick = 0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (eff[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/up_down_counter.sv
// Enable-gated up/down counter used as the shared credit register.
// Latency: count updates on the edge after enable/up are sampled.
// Backpressure: none; the owner guarantees no wrap.
module up_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  // Step by one in the requested direction when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      count <= up ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/tlp_credit_arbiter.sv
// Round-robin arbiter handing out TLP buffer credits from a shared pool.
// Latency: req sampled at an edge yields a one-cycle gnt from that edge.
// Backpressure: requests wait while credits are 0; returns at full are dropped and flagged.
module tlp_credit_arbiter
  import tlp_credit_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NREQ         = 4,
  parameter int INIT_CREDITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             credit_return,
  output logic [NREQ-1:0]  gnt,
  output logic [WIDTH-1:0] credits,
  output logic             ready,
  output logic             empty,
  output logic             full,
  output logic             overflow_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] FULL_CNT = WIDTH'(INIT_CREDITS);

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] eff_req;
  logic            grant_fire;
  logic            return_ok;
  logic            illegal_return;
  logic            cnt_en;
  logic            cnt_up;
  int              winner;

  up_down_counter #(.WIDTH(WIDTH)) u_credit_cnt (
    .clk    (clk),
    .reset  (reset),
    .enable (cnt_en),
    .up     (cnt_up),
    .count  (credits)
  );

  // State register: INIT until the pool is preloaded, then RUN until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // Next state, counter drive and grant/return qualification.
  always_comb begin
    state_nxt      = state;
    cnt_en         = 1'b0;
    cnt_up         = 1'b0;
    grant_fire     = 1'b0;
    return_ok      = 1'b0;
    illegal_return = 1'b0;
    // A requester still seeing its grant is masked so a late req drop
    // cannot earn it a second credit.
    eff_req        = req & ~gnt;
    winner         = rr_pick(MAX_REQ'(eff_req), int'(ptr), NREQ);
    case (state)
      ST_INIT: begin
        cnt_en         = 1'b1;
        cnt_up         = 1'b1;
        illegal_return = credit_return;
        if (credits == FULL_CNT - 1'b1) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        grant_fire     = (|eff_req) && (credits != '0);
        // At full a return is only legal if a grant frees a slot this cycle.
        return_ok      = credit_return && ((credits != FULL_CNT) || grant_fire);
        illegal_return = credit_return && !return_ok;
        // Simultaneous grant and return cancel out.
        cnt_en         = grant_fire ^ return_ok;
        cnt_up         = return_ok;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Grant register, round-robin pointer and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt          <= '0;
      ptr          <= PW'(NREQ - 1);
      overflow_err <= 1'b0;
    end else begin
      if (grant_fire) begin
        gnt <= NREQ'(1) << winner;
        ptr <= PW'(winner);
      end else begin
        gnt <= '0;
      end
      if (illegal_return) overflow_err <= 1'b1;
    end
  end

  assign ready = (state == ST_RUN);
  assign empty = (credits == '0);
  assign full  = (credits == FULL_CNT);

endmodule

// File: tb/tb_tlp_credit_arbiter.sv
module tb_tlp_credit_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int INIT  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  req;
  logic             credit_return;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] credits;
  logic             ready;
  logic             empty;
  logic             full;
  logic             overflow_err;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers, spec-level rules)
  bit m_run;
  int m_credits;
  int m_ptr;
  int m_gnt;
  bit m_ovf;

  tlp_credit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .INIT_CREDITS(INIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .credit_return (credit_return),
    .gnt           (gnt),
    .credits       (credits),
    .ready         (ready),
    .empty         (empty),
    .full          (full),
    .overflow_err  (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 0; m_credits = 0; m_ptr = NREQ - 1; m_gnt = 0; m_ovf = 0;
  endtask

  // Advance one clock; model consumes the inputs present before the edge.
  task automatic step();
    int eff, w, idx, nc, ngnt;
    bit fire, rok, nrun;
    nrun = m_run;
    w = m_ptr;
    ngnt = 0;
    if (!m_run) begin
      nc = m_credits + 1;
      if (credit_return) m_ovf = 1;
      nrun = (nc == INIT);
    end else begin
      eff = int'(req) & ~m_gnt & ((1 << NREQ) - 1);
      fire = (eff != 0) && (m_credits > 0);
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (w < 0 && eff[idx]) w = idx;
      end
      rok = credit_return && ((m_credits != INIT) || fire);
      if (credit_return && !rok) m_ovf = 1;
      nc = m_credits + int'(rok) - int'(fire);
      if (fire) ngnt = 1 << w;
      else w = m_ptr;
    end
    @(posedge clk);
    #1;
    m_credits = nc; m_gnt = ngnt; m_ptr = w; m_run = nrun;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; credit_return = 1'b0;
    model_reset();
    #2;
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got %b want 0", gnt); end
    checks++; if (credits !== '0) begin errors++; $display("FAIL reset_credits got %0d want 0", credits); end
    checks++; if (ready !== 1'b0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL reset_flags got ready=%b empty=%b full=%b want 0 1 0", ready, empty, full); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow_err); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_init();
    for (int i = 1; i <= INIT; i++) begin
      step();
      checks++; if (credits !== WIDTH'(i) || credits !== WIDTH'(m_credits)) begin
        errors++; $display("FAIL init_credits cycle %0d got %0d want %0d", i, credits, i); end
      checks++; if (ready !== (i == INIT) || full !== (i == INIT)) begin
        errors++; $display("FAIL init_ready cycle %0d got ready=%b full=%b want %b", i, ready, full, i == INIT); end
      checks++; if (gnt !== '0) begin errors++; $display("FAIL init_gnt cycle %0d got %b want 0", i, gnt); end
    end
  endtask

  task automatic test_rr_drain();
    logic [NREQ-1:0] exp;
    req = 4'b1111;
    for (int i = 0; i < INIT; i++) begin
      step();
      exp = NREQ'(1) << (i % NREQ);
      checks++; if (gnt !== exp || gnt !== NREQ'(m_gnt)) begin
        errors++; $display("FAIL rr_gnt grant %0d got %b want %b", i, gnt, exp); end
      checks++; if (credits !== WIDTH'(INIT - 1 - i)) begin
        errors++; $display("FAIL rr_credits grant %0d got %0d want %0d", i, credits, INIT - 1 - i); end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (gnt !== '0 || empty !== 1'b1) begin
        errors++; $display("FAIL rr_empty cycle %0d got gnt=%b empty=%b want 0 1", i, gnt, empty); end
    end
  endtask

  task automatic test_zero_return();
    req = 4'b0100;
    step();
    checks++; if (gnt !== '0 || credits !== '0) begin
      errors++; $display("FAIL zr_wait got gnt=%b credits=%0d want 0 0", gnt, credits); end
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    checks++; if (credits !== WIDTH'(1) || gnt !== '0) begin
      errors++; $display("FAIL zr_return got credits=%0d gnt=%b want 1 0", credits, gnt); end
    step();
    checks++; if (gnt !== 4'b0100 || credits !== '0) begin
      errors++; $display("FAIL zr_grant got gnt=%b credits=%0d want 0100 0", gnt, credits); end
    req = '0;
    step();
    checks++; if (gnt !== '0) begin errors++; $display("FAIL zr_after got %b want 0", gnt); end
  endtask

  task automatic test_simul();
    credit_return = 1'b1;
    repeat (5) step();
    checks++; if (credits !== WIDTH'(5)) begin errors++; $display("FAIL sim_fill got %0d want 5", credits); end
    req = 4'b0001;
    step();
    checks++; if (credits !== WIDTH'(5) || credits !== WIDTH'(m_credits)) begin
      errors++; $display("FAIL sim_credits got %0d want 5", credits); end
    checks++; if (gnt !== NREQ'(m_gnt) || gnt === '0) begin
      errors++; $display("FAIL sim_gnt got %b want %b", gnt, NREQ'(m_gnt)); end
    req = '0; credit_return = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    credit_return = 1'b1;
    repeat (3) step();
    checks++; if (credits !== WIDTH'(INIT) || full !== 1'b1 || overflow_err !== 1'b0) begin
      errors++; $display("FAIL ov_full got credits=%0d full=%b ovf=%b want 8 1 0", credits, full, overflow_err); end
    step();
    credit_return = 1'b0;
    checks++; if (credits !== WIDTH'(INIT) || overflow_err !== 1'b1) begin
      errors++; $display("FAIL ov_set got credits=%0d ovf=%b want 8 1", credits, overflow_err); end
    req = 4'b0010;
    step();
    req = '0; credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    checks++; if (credits !== WIDTH'(INIT) || overflow_err !== 1'b1) begin
      errors++; $display("FAIL ov_sticky got credits=%0d ovf=%b want 8 1", credits, overflow_err); end
  endtask

  task automatic test_init_return();
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ir_clear got %b want 0", overflow_err); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) step();
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    checks++; if (overflow_err !== 1'b1 || credits !== WIDTH'(4)) begin
      errors++; $display("FAIL ir_set got ovf=%b credits=%0d want 1 4", overflow_err, credits); end
    repeat (4) step();
    checks++; if (ready !== 1'b1 || credits !== WIDTH'(INIT)) begin
      errors++; $display("FAIL ir_run got ready=%b credits=%0d want 1 8", ready, credits); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req = NREQ'($urandom_range(0, 15));
      credit_return = ($urandom_range(0, 2) == 0);
      step();
      checks++; if (gnt !== NREQ'(m_gnt)) begin
        errors++; $display("FAIL rnd_gnt cycle %0d got %b want %b", i, gnt, NREQ'(m_gnt)); end
      checks++; if (credits !== WIDTH'(m_credits)) begin
        errors++; $display("FAIL rnd_credits cycle %0d got %0d want %0d", i, credits, m_credits); end
      checks++; if (empty !== (m_credits == 0) || full !== (m_credits == INIT) || overflow_err !== m_ovf) begin
        errors++; $display("FAIL rnd_flags cycle %0d got empty=%b full=%b ovf=%b want %b %b %b",
                           i, empty, full, overflow_err, m_credits == 0, m_credits == INIT, m_ovf); end
    end
    req = '0; credit_return = 1'b0;
    step();
  endtask

  task automatic test_mid_reset();
    // Bring the pool to full so the drain below lands on 3 credits.
    credit_return = 1'b1;
    for (int i = 0; i < 20 && m_credits < INIT; i++) step();
    credit_return = 1'b0;
    checks++; if (credits !== WIDTH'(INIT)) begin errors++; $display("FAIL mr_refill got %0d want 8", credits); end
    req = 4'b1111;
    repeat (INIT - 3) step();
    checks++; if (credits !== WIDTH'(3) || gnt === '0) begin
      errors++; $display("FAIL mr_pre got credits=%0d gnt=%b want 3 nonzero", credits, gnt); end
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (gnt !== '0 || credits !== '0 || ready !== 1'b0) begin
      errors++; $display("FAIL mr_async got gnt=%b credits=%0d ready=%b want 0 0 0", gnt, credits, ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 1; i <= INIT; i++) begin
      step();
      checks++; if (gnt !== '0 || credits !== WIDTH'(i)) begin
        errors++; $display("FAIL mr_init cycle %0d got gnt=%b credits=%0d want 0 %0d", i, gnt, credits, i); end
    end
    checks++; if (ready !== 1'b1 || overflow_err !== 1'b0) begin
      errors++; $display("FAIL mr_done got ready=%b ovf=%b want 1 0", ready, overflow_err); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_rr_drain();
    test_zero_return();
    test_simul();
    test_overflow();
    test_init_return();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlp_credit_arbiter.md
# tlp_credit_arbiter

Round-robin credit arbiter sharing a pool of TLP buffer credits among NREQ requesters. It sequences an internal up_down_counter that holds the available-credit count: the counter is preloaded after reset, decremented once per grant, and incremented once per returned credit. The block sits between the TLP detector's requesting stages and the shared buffer that consumes credits.

## Interface
- WIDTH, 8: credit counter width.
- NREQ, 4: number of requesters, ≥ 2.
- INIT_CREDITS, 8: pool size loaded after reset; 1 ≤ INIT_CREDITS ≤ 2^WIDTH−1.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester credit request, level.
- credit_return  in  1  one-cycle pulse; returns one credit.
- gnt  out  NREQ  one-hot grant, registered, high for one cycle per credit granted.
- credits  out  WIDTH  current available credits (counter value).
- ready  out  1  high in RUN state.
- empty  out  1  credits == 0.
- full  out  1  credits == INIT_CREDITS.
- overflow_err  out  1  sticky; set by an illegal credit return.

## Operation
- Reset values: gnt=0, credits=0, ready=0, empty=1, full=0, overflow_err=0; state=INIT; RR pointer=NREQ−1, so req[0] has top priority first.
- INIT: counter enable=1, up=1 every cycle; gnt held 0; req ignored. Move to RUN on the edge where credits reaches INIT_CREDITS.
- RUN: grant_fire = (|eff_req) && credits != 0, where eff_req = req & ~gnt. Masking means a requester dropping req while seeing gnt is never double-granted.
- Winner: the first set bit of eff_req scanning upward, with wrap, from pointer+1. On grant, gnt ← onehot(winner) and pointer ← winner. Otherwise gnt ← 0.
- return_ok = credit_return && state==RUN && (credits != INIT_CREDITS || grant_fire).
- Counter drive: enable = grant_fire XOR return_ok; up = return_ok. A simultaneous grant and return leaves credits unchanged.
- Illegal return: credit_return while in INIT, or while at full with no grant in that cycle. The return is dropped and overflow_err is set. It stays set until reset.
- At most one grant per cycle. Credits move by at most ±1 per cycle.
- empty and full are decoded combinationally from credits.

## Timing
- States: INIT → RUN, taken once INIT_CREDITS rising edges after reset deasserts. No return to INIT except via reset.
- ready asserts in the same cycle credits first equals INIT_CREDITS.
- Request-to-grant latency is 1 cycle: req sampled at edge k gives gnt high from edge k to edge k+1, and credits decremented at edge k.
- A requester holding req continuously is re-granted at best every other cycle while others request. With a sole requester and eff_req masking, it is likewise granted every other cycle.
- credits at 0: no grant; requests wait. A return in that cycle makes credits=1, and a grant is possible the following cycle.
- Reset mid-operation: all state clears immediately (asynchronous), outstanding grants are void, and INIT reruns. Requesters must discard held credits on reset.

## Structure
- Shared package tlp_credit_pkg: state enum (ST_INIT, ST_RUN) and the NREQ-generic round-robin pick function.
- One sub-module: instantiate the existing up_down_counter #(.WIDTH(WIDTH)) as the credit register. Connect clk and reset, with enable/up driven as above; its count drives credits.
- The FSM, RR pointer, gnt register and overflow_err flag live in this block.

## Test plan
- Reset, then release with no traffic (INIT_CREDITS=8) → credits counts 1..8 over 8 cycles. ready and full rise at credits=8, and gnt stays 0 throughout.
- req=4'b1111 held in RUN → gnt sequence 0001, 0010, 0100, 1000, 0001… until credits reaches 0. Then empty=1 and gnt=0 while req stays high.
- At credits=0 with req[2]=1, pulse credit_return → credits goes 0→1, then gnt=0100 the next cycle and credits goes to 0.
- At credits=5, a grant and credit_return in the same cycle → credits stays 5 and gnt fires.
- At full (8), a credit_return with no req → credits stays 8 and overflow_err=1, remaining 1 after later legal traffic. A credit_return during INIT → also sets overflow_err.
- Assert reset mid-RUN with credits=3 and gnt active → gnt=0, credits=0, ready=0 immediately. After release, INIT reruns to 8 and overflow_err is cleared.
